alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer slice.
//   op_e    : command opcodes (NOP / LOAD / MOV / AFF)
//   state_e : sequencer FSM states
//   cmd_t   : queued command {op, rd, rs1, rs2, imm}
package alu_seq_pkg;

  localparam int unsigned BUS_WIDTH  = 8;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_MOV  = 2'b10,
    OP_AFF  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SETTLE,
    ST_WRITE
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [ADDR_W-1:0]    rd;
    logic [ADDR_W-1:0]    rs1;
    logic [ADDR_W-1:0]    rs2;
    logic [BUS_WIDTH-1:0] imm;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Two-entry command FIFO.
//   clk, rst        : clock, synchronous active-high flush
//   push, push_data : write strobe and payload (ignored when full)
//   pop, pop_data   : read strobe (ignored when empty) and head payload
//   full, empty     : occupancy flags
module cmd_fifo
  import alu_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  cmd_t       mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences queued commands through an external register file and ALU.
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake (ready = FIFO not full)
//   cmd_op/rd/rs1/rs2/imm         : command fields
//   rf_rd_addr_a/b                : register-file read addresses (data next cycle)
//   rf_wr_en/addr/data            : register-file write port
//   alu_reg_en                    : ALU operand-register enables [a,b,c,d,e]
//   alu_f_add, alu_f_load, alu_imm: ALU mux selects and immediate
//   alu_result                    : ALU combinational result
//   busy, done                    : activity flag and retirement pulse
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_rd,
  input  logic [ADDR_W-1:0]    cmd_rs1,
  input  logic [ADDR_W-1:0]    cmd_rs2,
  input  logic [BUS_WIDTH-1:0] cmd_imm,
  output logic [ADDR_W-1:0]    rf_rd_addr_a,
  output logic [ADDR_W-1:0]    rf_rd_addr_b,
  output logic                 rf_wr_en,
  output logic [ADDR_W-1:0]    rf_wr_addr,
  output logic [BUS_WIDTH-1:0] rf_wr_data,
  output logic [4:0]           alu_reg_en,
  output logic                 alu_f_add,
  output logic                 alu_f_load,
  output logic [BUS_WIDTH-1:0] alu_imm,
  input  logic [BUS_WIDTH-1:0] alu_result,
  output logic                 busy,
  output logic                 done
);

  state_e               state;
  state_e               state_nx;
  cmd_t                 cmd_in;
  cmd_t                 head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 load_cmd;

  op_e                  op_q;
  logic [ADDR_W-1:0]    rd_q;
  logic [BUS_WIDTH-1:0] imm_q;
  logic [ADDR_W-1:0]    rd_addr_a_q;
  logic [ADDR_W-1:0]    rd_addr_b_q;
  logic [ADDR_W-1:0]    wr_addr_q;

  logic                 done_c;
  logic                 wr_en_c;
  logic [4:0]           reg_en_c;
  logic                 f_add_c;
  logic                 f_load_c;
  logic [BUS_WIDTH-1:0] imm_c;

  always_comb begin
    cmd_in     = '0;
    cmd_in.op  = op_e'(cmd_op);
    cmd_in.rd  = cmd_rd;
    cmd_in.rs1 = cmd_rs1;
    cmd_in.rs2 = cmd_rs2;
    cmd_in.imm = cmd_imm;
  end

  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  cmd_fifo u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_NOP;
      rd_q        <= '0;
      imm_q       <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_addr_q   <= '0;
    end else begin
      state <= state_nx;
      if (load_cmd) begin
        op_q        <= head.op;
        rd_q        <= head.rd;
        imm_q       <= head.imm;
        rd_addr_a_q <= head.rs1;
        rd_addr_b_q <= head.rs2;
      end
      // Write address is registered on entry to WRITE so it holds afterwards.
      if (state == ST_SETTLE) begin
        wr_addr_q <= rd_q;
      end
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load_cmd = 1'b0;
    done_c   = 1'b0;
    wr_en_c  = 1'b0;
    reg_en_c = '0;
    f_add_c  = 1'b0;
    f_load_c = 1'b0;
    imm_c    = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // A NOP retires straight from the FIFO head without leaving IDLE.
          if (head.op == OP_NOP) begin
            done_c = 1'b1;
          end else begin
            load_cmd = 1'b1;
            state_nx = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        reg_en_c = '1;
        imm_c    = imm_q;
        case (op_q)
          OP_MOV:  f_load_c = 1'b1;
          OP_AFF:  f_add_c  = 1'b1;
          default: ;
        endcase
        state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_c  = 1'b1;
        done_c   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Every output is forced low while rst is asserted.
  assign rf_rd_addr_a = rst ? '0 : rd_addr_a_q;
  assign rf_rd_addr_b = rst ? '0 : rd_addr_b_q;
  assign rf_wr_addr   = rst ? '0 : wr_addr_q;
  assign rf_wr_en     = !rst && wr_en_c;
  assign rf_wr_data   = (!rst && wr_en_c) ? alu_result : '0;
  assign alu_reg_en   = rst ? '0 : reg_en_c;
  assign alu_f_add    = !rst && f_add_c;
  assign alu_f_load   = !rst && f_load_c;
  assign alu_imm      = rst ? '0 : imm_c;
  assign busy         = !rst && ((state != ST_IDLE) || !fifo_empty);
  assign done         = !rst && done_c;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register-file and ALU environment models, an
// instruction-level reference model, and one task per scenario.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [7:0] cmd_imm = '0;
  logic [2:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic       rf_wr_en;
  logic [7:0] rf_wr_data;
  logic [4:0] alu_reg_en;
  logic       alu_f_add, alu_f_load;
  logic [7:0] alu_imm;
  logic [7:0] alu_result;
  logic       busy, done;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_reg_en(alu_reg_en), .alu_f_add(alu_f_add), .alu_f_load(alu_f_load),
    .alu_imm(alu_imm), .alu_result(alu_result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: register file with one-cycle read latency, and an ALU whose
  // operand registers feed result = b*d + c*d + e (8-bit wrap).
  logic [7:0] rf [8] = '{default: 8'h00};
  logic [7:0] data_a = '0, data_b = '0, sw = '0;
  logic [7:0] alu_b = '0, alu_c = '0, alu_d = '0, alu_e = '0;

  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    data_a <= rf[rf_rd_addr_a];
    data_b <= rf[rf_rd_addr_b];
    if (alu_reg_en[3]) alu_b <= data_a;
    if (alu_reg_en[2]) alu_c <= data_b;
    if (alu_reg_en[1]) alu_d <= alu_f_add ? alu_imm : 8'h00;
    if (alu_reg_en[0]) alu_e <= alu_f_add ? alu_imm : (alu_f_load ? data_a : sw);
  end
  assign alu_result = alu_b * alu_d + alu_c * alu_d + alu_e;

  // Event logs; "at" is the index of the posedge the event is committed on.
  typedef struct { int at; logic [2:0] addr; logic [7:0] data; logic dn; } wr_rec_t;
  typedef struct { int at; logic [4:0] en; logic fl; logic fa; logic [7:0] imm; } cap_rec_t;
  typedef struct { logic [2:0] addr; logic [7:0] data; } exp_rec_t;

  wr_rec_t  wr_log[$];
  cap_rec_t cap_log[$];
  int       nop_log[$];
  exp_rec_t exp_wr[$];
  int       exp_nop = 0;
  wr_rec_t  wr_tmp;
  cap_rec_t cap_tmp;

  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wr_en) begin
        wr_tmp.at = cyc + 1; wr_tmp.addr = rf_wr_addr; wr_tmp.data = rf_wr_data; wr_tmp.dn = done;
        wr_log.push_back(wr_tmp);
      end
      if (done && !rf_wr_en) nop_log.push_back(cyc + 1);
      if (alu_reg_en != 5'b00000) begin
        cap_tmp.at = cyc + 1; cap_tmp.en = alu_reg_en; cap_tmp.fl = alu_f_load;
        cap_tmp.fa = alu_f_add; cap_tmp.imm = alu_imm;
        cap_log.push_back(cap_tmp);
      end
    end
  end

  // Reference model: architectural register file, updated in command order.
  logic [7:0] ref_rf [8] = '{default: 8'h00};
  int vectors = 0;
  int miscompares = 0;

  task automatic clear_logs();
    wr_log.delete(); cap_log.delete(); nop_log.delete(); exp_wr.delete(); exp_nop = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [7:0] imm, output int acc);
    int s;
    logic [7:0] v;
    exp_rec_t e;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    acc = -1;
    for (int i = 0; i < 64 && acc < 0; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) acc = cyc + 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (acc < 0) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: cmd_ready got 0 for 64 cycles, expected 1");
    end else if (op == 2'b00) begin
      exp_nop++;
    end else begin
      case (op)
        2'b01:   v = sw;
        2'b10:   v = ref_rf[rs1];
        default: begin
          s = int'($signed(ref_rf[rs1])) * int'($signed(imm))
            + int'($signed(ref_rf[rs2])) * int'($signed(imm)) + int'($signed(imm));
          v = s[7:0];
        end
      endcase
      ref_rf[rd] = v;
      e.addr = rd; e.data = v;
      exp_wr.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: busy got 1 for 300 cycles, expected 0");
    end
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = 3'd3; cmd_imm = 8'hA5;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    outs = {cmd_ready, busy, done, rf_wr_en, alu_reg_en, alu_f_add, alu_f_load,
            rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, rf_wr_data, alu_imm};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b busy=%b, expected ready=1 busy=0", cmd_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    int acc;
    clear_logs();
    sw = 8'h5A;
    send(2'b01, 3'd1, 3'd0, 3'd0, 8'h3C, acc);
    wait_idle();
    vectors++;
    if (wr_log.size() != 1) begin
      miscompares++;
      $display("FAIL load_write_count: got %0d, expected 1", wr_log.size());
    end
    if (wr_log.size() > 0) begin
      vectors++;
      if (wr_log[0].at != acc + 5 || wr_log[0].addr !== 3'd1 || wr_log[0].data !== 8'h5A || wr_log[0].dn !== 1'b1) begin
        miscompares++;
        $display("FAIL load_write: got at=%0d addr=%0d data=%h done=%b, expected at=%0d addr=1 data=5a done=1",
                 wr_log[0].at - acc, wr_log[0].addr, wr_log[0].data, wr_log[0].dn, 5);
      end
    end
    vectors++;
    if (cap_log.size() != 1) begin
      miscompares++;
      $display("FAIL load_capture_count: got %0d, expected 1", cap_log.size());
    end
    if (cap_log.size() > 0) begin
      vectors++;
      if (cap_log[0].at != acc + 3 || cap_log[0].en !== 5'b11111 || cap_log[0].fl !== 1'b0 ||
          cap_log[0].fa !== 1'b0 || cap_log[0].imm !== 8'h3C) begin
        miscompares++;
        $display("FAIL load_capture: got at=T+%0d en=%b fl=%b fa=%b imm=%h, expected at=T+3 en=11111 fl=0 fa=0 imm=3c",
                 cap_log[0].at - acc, cap_log[0].en, cap_log[0].fl, cap_log[0].fa, cap_log[0].imm);
      end
    end
  endtask

  task automatic test_aff();
    int acc;
    logic [7:0] req [2];
    clear_logs();
    sw = 8'd2;   send(2'b01, 3'd1, 3'd0, 3'd0, 8'h00, acc); wait_idle();
    sw = 8'd3;   send(2'b01, 3'd2, 3'd0, 3'd0, 8'h00, acc); wait_idle();
    send(2'b11, 3'd5, 3'd1, 3'd2, 8'd4, acc); wait_idle();
    sw = 8'd100; send(2'b01, 3'd1, 3'd0, 3'd0, 8'h00, acc); wait_idle();
    send(2'b01, 3'd2, 3'd0, 3'd0, 8'h00, acc); wait_idle();
    send(2'b11, 3'd5, 3'd1, 3'd2, 8'd1, acc); wait_idle();
    req[0] = 8'd24; req[1] = 8'hC9;
    vectors++;
    if (wr_log.size() != 6 || cap_log.size() != 6) begin
      miscompares++;
      $display("FAIL aff_counts: got writes=%0d captures=%0d, expected 6 and 6", wr_log.size(), cap_log.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (wr_log[2 + 3*k].addr !== 3'd5 || wr_log[2 + 3*k].data !== req[k] || exp_wr[2 + 3*k].data !== req[k]) begin
          miscompares++;
          $display("FAIL aff_result%0d: got addr=%0d data=%h, expected addr=5 data=%h",
                   k, wr_log[2 + 3*k].addr, wr_log[2 + 3*k].data, req[k]);
        end
        vectors++;
        if (cap_log[2 + 3*k].fa !== 1'b1 || cap_log[2 + 3*k].fl !== 1'b0) begin
          miscompares++;
          $display("FAIL aff_selects%0d: got fa=%b fl=%b, expected fa=1 fl=0",
                   k, cap_log[2 + 3*k].fa, cap_log[2 + 3*k].fl);
        end
      end
    end
  endtask

  task automatic test_mov_hazard();
    int acc0, acc1;
    clear_logs();
    sw = 8'd7;
    send(2'b01, 3'd1, 3'd0, 3'd0, 8'h00, acc0);
    send(2'b10, 3'd2, 3'd1, 3'd0, 8'h00, acc1);
    wait_idle();
    vectors++;
    if (wr_log.size() != 2 || cap_log.size() != 2) begin
      miscompares++;
      $display("FAIL mov_counts: got writes=%0d captures=%0d, expected 2 and 2", wr_log.size(), cap_log.size());
    end else begin
      vectors++;
      if (wr_log[1].addr !== 3'd2 || wr_log[1].data !== 8'd7 || wr_log[1].at != wr_log[0].at + 5) begin
        miscompares++;
        $display("FAIL mov_hazard: got addr=%0d data=%h gap=%0d, expected addr=2 data=07 gap=5",
                 wr_log[1].addr, wr_log[1].data, wr_log[1].at - wr_log[0].at);
      end
      vectors++;
      if (cap_log[1].fl !== 1'b1 || cap_log[1].fa !== 1'b0) begin
        miscompares++;
        $display("FAIL mov_selects: got fl=%b fa=%b, expected fl=1 fa=0", cap_log[1].fl, cap_log[1].fa);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    clear_logs();
    sw = 8'($urandom);
    for (int i = 0; i < 3; i++)
      send(2'($urandom_range(1, 3)), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), acc[i]);
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b0 || acc[2] != acc[0] + 2) begin
      miscompares++;
      $display("FAIL b2b_ready: got ready=%b accept_span=%0d, expected ready=0 accept_span=2",
               cmd_ready, acc[2] - acc[0]);
    end
    @(posedge clk); #1;
    wait_idle();
    vectors++;
    if (wr_log.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d, expected 3", wr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_log[i].at != acc[0] + 5 * (i + 1) || wr_log[i].addr !== exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data) begin
          miscompares++;
          $display("FAIL b2b_write%0d: got at=T+%0d addr=%0d data=%h, expected at=T+%0d addr=%0d data=%h",
                   i, wr_log[i].at - acc[0], wr_log[i].addr, wr_log[i].data,
                   5 * (i + 1), exp_wr[i].addr, exp_wr[i].data);
        end
      end
    end
  endtask

  task automatic test_nop();
    int acc;
    clear_logs();
    sw = 8'h11;
    send(2'b01, 3'd3, 3'd0, 3'd0, 8'h00, acc);
    send(2'b00, 3'd0, 3'd0, 3'd0, 8'h00, acc);
    send(2'b01, 3'd4, 3'd0, 3'd0, 8'h00, acc);
    wait_idle();
    vectors++;
    if (wr_log.size() != 2 || nop_log.size() != 1 || cap_log.size() != 2) begin
      miscompares++;
      $display("FAIL nop_counts: got writes=%0d nops=%0d captures=%0d, expected 2 1 2",
               wr_log.size(), nop_log.size(), cap_log.size());
    end else begin
      vectors++;
      if (nop_log[0] != wr_log[0].at + 1 || cap_log[1].at != nop_log[0] + 3 || wr_log[1].at != nop_log[0] + 5) begin
        miscompares++;
        $display("FAIL nop_timing: got nop=W+%0d cap=N+%0d write=N+%0d, expected W+1 N+3 N+5",
                 nop_log[0] - wr_log[0].at, cap_log[1].at - nop_log[0], wr_log[1].at - nop_log[0]);
      end
      vectors++;
      if (wr_log[1].addr !== 3'd4 || wr_log[1].data !== 8'h11) begin
        miscompares++;
        $display("FAIL nop_second_load: got addr=%0d data=%h, expected addr=4 data=11", wr_log[1].addr, wr_log[1].data);
      end
    end
  endtask

  task automatic test_random();
    int acc;
    int n;
    clear_logs();
    sw = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), acc);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle();
    vectors++;
    if (wr_log.size() != exp_wr.size() || nop_log.size() != exp_nop) begin
      miscompares++;
      $display("FAIL rand_counts: got writes=%0d nops=%0d, expected %0d %0d",
               wr_log.size(), nop_log.size(), exp_wr.size(), exp_nop);
    end
    n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (wr_log[i].addr !== exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data ||
          (i > 0 && wr_log[i].at - wr_log[i-1].at < 5)) begin
        miscompares++;
        $display("FAIL rand_write%0d: got addr=%0d data=%h gap=%0d, expected addr=%0d data=%h gap>=5",
                 i, wr_log[i].addr, wr_log[i].data, (i > 0) ? wr_log[i].at - wr_log[i-1].at : 5,
                 exp_wr[i].addr, exp_wr[i].data);
      end
    end
  endtask

  task automatic test_reset_write();
    int acc;
    bit hit = 1'b0;
    logic [7:0] old6;
    clear_logs();
    old6 = ref_rf[6];
    sw = ~old6;
    send(2'b01, 3'd6, 3'd0, 3'd0, 8'h00, acc);
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (rf_wr_en === 1'b1) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rstw_reach_write: got no write cycle, expected one");
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (rf_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstw_after: got wr_en=%b busy=%b done=%b, expected 0 0 0", rf_wr_en, busy, done);
    end
    @(posedge clk); #1;
    ref_rf[6] = old6;
    clear_logs();
    send(2'b10, 3'd7, 3'd6, 3'd0, 8'h00, acc);
    wait_idle();
    vectors++;
    if (wr_log.size() != 1 || wr_log[0].data !== old6 || exp_wr[0].data !== old6) begin
      miscompares++;
      $display("FAIL rstw_no_commit: got writes=%0d data=%h, expected 1 write of %h",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0].data : 8'h00, old6);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_aff();
    test_mov_hazard();
    test_back_to_back();
    test_nop();
    test_random();
    test_reset_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
